// File: rtl/seq_shift_unit.sv
// Multicycle SLL/SRL/SRA unit: one bit per clock under a start/busy/done handshake.
// Optional rotate-right on op=11 when SEQ_SHIFT_ROTATE_EN is defined.
module seq_shift_unit #(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        op,
   input  logic [DATA_W-1:0] data_in,
   input  logic [AMT_W-1:0]  amt_in,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] result
);

   localparam int CNT_W = $clog2(DATA_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [DATA_W-1:0] work;
   logic [DATA_W-1:0] shifted;
   logic [1:0]        op_q;
   logic              sign_q;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  n_eff;

   // Amounts at or above DATA_W saturate; DATA_W single-bit steps give the saturated result.
   always_comb begin
      n_eff = '0;
      if (op == 2'b11) begin
`ifdef SEQ_SHIFT_ROTATE_EN
         n_eff = CNT_W'(amt_in % AMT_W'(DATA_W));
`else
         n_eff = '0;
`endif
      end else if (amt_in >= AMT_W'(DATA_W)) begin
         n_eff = CNT_W'(DATA_W);
      end else begin
         n_eff = amt_in[CNT_W-1:0];
      end
   end

   always_comb begin
      shifted = work;
      case (op_q)
         2'b00:   shifted = {work[DATA_W-2:0], 1'b0};
         2'b01:   shifted = {1'b0, work[DATA_W-1:1]};
         2'b10:   shifted = {sign_q, work[DATA_W-1:1]};
`ifdef SEQ_SHIFT_ROTATE_EN
         2'b11:   shifted = {work[0], work[DATA_W-1:1]};
`endif
         default: shifted = work;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         work   <= '0;
         op_q   <= '0;
         sign_q <= 1'b0;
         count  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  work   <= data_in;
                  op_q   <= op;
                  sign_q <= data_in[DATA_W-1];
                  count  <= n_eff;
                  busy   <= 1'b1;
                  if (n_eff == '0) begin
                     state  <= DONE;
                     done   <= 1'b1;
                     result <= data_in;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            SHIFT: begin
               work  <= shifted;
               count <= count - CNT_W'(1);
               // Last step: publish the final value together with the done pulse.
               if (count == CNT_W'(1)) begin
                  state  <= DONE;
                  done   <= 1'b1;
                  result <= shifted;
               end
            end
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
